// File: rtl/rtdf_sample_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtdf_sample_unpacker_pkg
// Description : Shared defaults and helpers for the RTDF sample unpacker.
// Revision    : 1.0 - initial release
// ============================================================================

package rtdf_sample_unpacker_pkg;

    localparam int c_default_word_width   = 16;
    localparam int c_default_sample_width = 3;
    localparam int c_default_buffer_width = 32;
    localparam int c_default_cnt_width    = 16;

    // True when a whole FIFO word fits on top of the given fill level.
    function automatic logic word_fits(input int fill, input int word_width,
                                       input int buffer_width);
        return (fill + word_width) <= buffer_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtdf_sample_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module      : rtdf_sample_unpacker_if
// Description : Show-ahead word FIFO read port between FIFO and unpacker.
// Revision    : 1.0 - initial release
// ============================================================================

interface rtdf_sample_unpacker_if
    import rtdf_sample_unpacker_pkg::*;
#(
    parameter int WORD_WIDTH = c_default_word_width
);
    logic                  word_empty;
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_read;

    modport master (output word_empty, output word_data, input word_read);
    modport slave  (input word_empty, input word_data, output word_read);
endinterface

`default_nettype wire

// File: rtl/rtdf_sample_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : rtdf_sample_unpacker
// Description : Re-serialises packed FIFO words LSB-first into strobed samples.
// Revision    : 1.0 - initial release
// ============================================================================

module rtdf_sample_unpacker
    import rtdf_sample_unpacker_pkg::*;
#(
    parameter int WORD_WIDTH   = c_default_word_width,
    parameter int SAMPLE_WIDTH = c_default_sample_width,
    parameter int BUFFER_WIDTH = c_default_buffer_width,
    parameter int CNT_WIDTH    = c_default_cnt_width
)(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               sample_en,
    input  logic                               flush,
    rtdf_sample_unpacker_if.slave              word_if,
    output logic                               sample_valid,
    output logic [SAMPLE_WIDTH-1:0]            sample_data,
    output logic [$clog2(BUFFER_WIDTH+1)-1:0]  bits_available,
    output logic [CNT_WIDTH-1:0]               underrun_count,
    output logic [CNT_WIDTH-1:0]               word_count
);

    localparam int c_fill_w = $clog2(BUFFER_WIDTH + 1);

    if (BUFFER_WIDTH < WORD_WIDTH + SAMPLE_WIDTH - 1) begin : g_buffer_too_small
        $error("rtdf_sample_unpacker: BUFFER_WIDTH must be >= WORD_WIDTH+SAMPLE_WIDTH-1");
    end
    if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > 8) begin : g_bad_sample_width
        $error("rtdf_sample_unpacker: SAMPLE_WIDTH must be in 1..8");
    end

    logic [BUFFER_WIDTH-1:0] r_bits;
    logic [BUFFER_WIDTH-1:0] w_bits_next;
    logic [BUFFER_WIDTH-1:0] w_word_ext;
    logic [c_fill_w-1:0]     r_cnt;
    logic [c_fill_w-1:0]     w_rem;
    logic [c_fill_w-1:0]     w_cnt_next;
    logic                    w_take;
    logic                    w_starve;
    logic                    w_read;

    // The pop decision is made on the post-take fill so a take and a pop
    // can share a cycle and sustain one sample per clock.
    always_comb begin
        w_take      = sample_en && !flush && (int'(r_cnt) >= SAMPLE_WIDTH);
        w_starve    = sample_en && !flush && (int'(r_cnt) < SAMPLE_WIDTH);
        w_rem       = w_take ? (r_cnt - c_fill_w'(SAMPLE_WIDTH)) : r_cnt;
        w_read      = !word_if.word_empty && !flush && !reset &&
                      word_fits(int'(w_rem), WORD_WIDTH, BUFFER_WIDTH);
        w_word_ext  = BUFFER_WIDTH'(word_if.word_data);
        w_bits_next = w_take ? (r_bits >> SAMPLE_WIDTH) : r_bits;
        w_cnt_next  = w_rem;
        if (w_read) begin
            w_bits_next = w_bits_next | (w_word_ext << w_rem);
            w_cnt_next  = w_rem + c_fill_w'(WORD_WIDTH);
        end
    end

    assign word_if.word_read = w_read;
    assign bits_available    = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bits         <= '0;
            r_cnt          <= '0;
            sample_valid   <= 1'b0;
            sample_data    <= '0;
            underrun_count <= '0;
            word_count     <= '0;
        end else if (flush) begin
            r_bits       <= '0;
            r_cnt        <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_bits       <= w_bits_next;
            r_cnt        <= w_cnt_next;
            sample_valid <= w_take;
            if (w_take) begin
                sample_data <= r_bits[SAMPLE_WIDTH-1:0];
            end
            if (w_starve && (underrun_count != '1)) begin
                underrun_count <= underrun_count + CNT_WIDTH'(1);
            end
            if (w_read && (word_count != '1)) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rtdf_sample_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtdf_sample_unpacker
// Description : Directed self-checking bench for rtdf_sample_unpacker.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_rtdf_sample_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: default widths
    logic        reset_a, sample_en_a, flush_a, valid_a;
    logic [2:0]  data_a;
    logic [5:0]  bits_a;
    logic [15:0] underrun_a, words_a;
    rtdf_sample_unpacker_if #(.WORD_WIDTH(16)) ifa ();

    // DUT B: 2-bit samples, 4-bit counters
    logic        reset_b, sample_en_b, flush_b, valid_b;
    logic [1:0]  data_b;
    logic [5:0]  bits_b;
    logic [3:0]  underrun_b, words_b;
    rtdf_sample_unpacker_if #(.WORD_WIDTH(16)) ifb ();

    rtdf_sample_unpacker #(.WORD_WIDTH(16), .SAMPLE_WIDTH(3), .BUFFER_WIDTH(32), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset_a), .sample_en(sample_en_a), .flush(flush_a), .word_if(ifa),
        .sample_valid(valid_a), .sample_data(data_a), .bits_available(bits_a),
        .underrun_count(underrun_a), .word_count(words_a)
    );

    rtdf_sample_unpacker #(.WORD_WIDTH(16), .SAMPLE_WIDTH(2), .BUFFER_WIDTH(32), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset_b), .sample_en(sample_en_b), .flush(flush_b), .word_if(ifb),
        .sample_valid(valid_b), .sample_data(data_b), .bits_available(bits_b),
        .underrun_count(underrun_b), .word_count(words_b)
    );

    // Show-ahead FIFO models: head advances on a pop, tail on a push.
    logic [15:0] mem_a [0:63];
    logic [15:0] mem_b [0:63];
    int head_a = 0, tail_a = 0, head_b = 0, tail_b = 0;

    assign ifa.word_empty = (head_a == tail_a);
    assign ifa.word_data  = mem_a[head_a % 64];
    assign ifb.word_empty = (head_b == tail_b);
    assign ifb.word_data  = mem_b[head_b % 64];

    always @(posedge clk) begin
        if (ifa.word_read && (head_a != tail_a)) head_a <= head_a + 1;
        if (ifb.word_read && (head_b != tail_b)) head_b <= head_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [15:0] v);
        mem_a[tail_a % 64] = v;
        tail_a = tail_a + 1;
    endtask

    task automatic push_b(input logic [15:0] v);
        mem_b[tail_b % 64] = v;
        tail_b = tail_b + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [2:0] exp_a [0:9] = '{3'd6, 3'd0, 3'd3, 3'd5, 3'd7, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b1; sample_en_a = 1'b0; flush_a = 1'b0;
        reset_b = 1'b1; sample_en_b = 1'b0; flush_b = 1'b0;

        // Reset state, with a non-empty FIFO that must not be popped
        push_a(16'hFAC6);
        push_a(16'h0000);
        tick(); tick();
        #1;
        check("a_rst_no_pop", 32'(ifa.word_read), 32'd0);
        check("a_rst_valid", 32'(valid_a), 32'd0);
        check("a_rst_data", 32'(data_a), 32'd0);
        check("a_rst_bits", 32'(bits_a), 32'd0);
        check("a_rst_underrun", 32'(underrun_a), 32'd0);
        check("a_rst_words", 32'(words_a), 32'd0);
        check("b_rst_bits", 32'(bits_b), 32'd0);

        // Stream 0xFAC6, 0x0000 at one sample per clock
        reset_a = 1'b0; reset_b = 1'b0;
        tick();
        check("a_fill_first_word", 32'(bits_a), 32'd16);
        check("a_words_first", 32'(words_a), 32'd1);
        sample_en_a = 1'b1;
        tick();
        check("a_s0_valid", 32'(valid_a), 32'd1);
        check("a_s0_data", 32'(data_a), 32'(exp_a[0]));
        check("a_fill_take_and_pop", 32'(bits_a), 32'd29);
        check("a_words_second", 32'(words_a), 32'd2);
        for (int k = 1; k < 10; k++) begin
            tick();
            check("a_stream_valid", 32'(valid_a), 32'd1);
            check("a_stream_data", 32'(data_a), 32'(exp_a[k]));
        end
        check("a_stream_left", 32'(bits_a), 32'd2);
        check("a_stream_no_underrun", 32'(underrun_a), 32'd0);
        tick(); tick(); tick();
        check("a_starve_valid", 32'(valid_a), 32'd0);
        check("a_starve_underrun", 32'(underrun_a), 32'd3);
        check("a_starve_words", 32'(words_a), 32'd2);
        check("a_starve_bits_kept", 32'(bits_a), 32'd2);

        // Flush clears the residue, counters untouched
        sample_en_a = 1'b0; flush_a = 1'b1;
        tick();
        check("a_flush_bits", 32'(bits_a), 32'd0);
        check("a_flush_underrun", 32'(underrun_a), 32'd3);
        flush_a = 1'b0;
        push_a(16'h1111);
        push_a(16'h2222);
        tick(); tick();
        check("a_fill_full", 32'(bits_a), 32'd32);
        check("a_words_four", 32'(words_a), 32'd4);
        sample_en_a = 1'b1;
        repeat (6) tick();
        check("a_straddle_data", 32'(data_a), 32'd4);
        tick();
        check("a_fill_eleven", 32'(bits_a), 32'd11);

        // Flush with 11 bits buffered and sample_en high
        push_a(16'h0005);
        flush_a = 1'b1;
        #1;
        check("a_flush_no_pop", 32'(ifa.word_read), 32'd0);
        tick();
        check("a_flush_valid", 32'(valid_a), 32'd0);
        check("a_flush_bits_zero", 32'(bits_a), 32'd0);
        check("a_flush_words", 32'(words_a), 32'd4);
        flush_a = 1'b0; sample_en_a = 1'b0;
        tick();
        check("a_realign_bits", 32'(bits_a), 32'd16);
        sample_en_a = 1'b1;
        tick();
        check("a_realign_valid", 32'(valid_a), 32'd1);
        check("a_realign_data", 32'(data_a), 32'd5);
        sample_en_a = 1'b0;

        // Reset mid-stream with words waiting in the FIFO
        push_a(16'h0ABC);
        push_a(16'h0123);
        reset_a = 1'b1;
        #1;
        check("a_midrst_no_pop", 32'(ifa.word_read), 32'd0);
        tick();
        check("a_midrst_valid", 32'(valid_a), 32'd0);
        check("a_midrst_data", 32'(data_a), 32'd0);
        check("a_midrst_bits", 32'(bits_a), 32'd0);
        check("a_midrst_underrun", 32'(underrun_a), 32'd0);
        check("a_midrst_words", 32'(words_a), 32'd0);
        reset_a = 1'b0;
        tick(); tick();
        check("a_resume_bits", 32'(bits_a), 32'd32);
        sample_en_a = 1'b1;
        tick();
        check("a_resume_data0", 32'(data_a), 32'd4);
        tick();
        check("a_resume_data1", 32'(data_a), 32'd7);
        sample_en_a = 1'b0;

        // Starved pulses on an empty FIFO, then a late word
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample_en_a = 1'b1;
            tick();
            check("a_pulse_valid", 32'(valid_a), 32'd0);
            sample_en_a = 1'b0;
            tick();
        end
        check("a_pulse_underrun", 32'(underrun_a), 32'd5);
        push_a(16'h0007);
        tick();
        check("a_late_bits", 32'(bits_a), 32'd16);
        sample_en_a = 1'b1;
        tick();
        check("a_late_valid", 32'(valid_a), 32'd1);
        check("a_late_data", 32'(data_a), 32'd7);
        check("a_late_underrun", 32'(underrun_a), 32'd5);
        sample_en_a = 1'b0;

        // DUT B: all-ones stream, 2-bit samples every third cycle
        for (int k = 0; k < 4; k++) push_b(16'hFFFF);
        tick(); tick();
        check("b_fill_full", 32'(bits_b), 32'd32);
        for (int i = 0; i < 30; i++) begin
            sample_en_b = (i % 3 == 0);
            tick();
            check("b_stream_valid", 32'(valid_b), 32'((i % 3) == 0));
            if ((i % 3) == 0) check("b_stream_data", 32'(data_b), 32'd3);
            check("b_fill_le32", 32'(bits_b <= 6'd32), 32'd1);
        end
        sample_en_b = 1'b0;
        check("b_stream_underrun", 32'(underrun_b), 32'd0);

        // DUT B: underrun counter saturates at 15
        tail_b = head_b;
        flush_b = 1'b1;
        tick();
        flush_b = 1'b0;
        sample_en_b = 1'b1;
        repeat (15) tick();
        check("b_underrun_15", 32'(underrun_b), 32'd15);
        repeat (5) tick();
        check("b_underrun_sat", 32'(underrun_b), 32'd15);
        check("b_sat_valid", 32'(valid_b), 32'd0);
        sample_en_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
